// File: rtl/pattern_match_sched.sv
// rtl/pattern_match_sched.sv - round-robin shared 1-2-3 symbol-sequence detector
//
// Purpose:
//   One detection engine time-shared between NCH requesters. A round-robin
//   arbiter accepts at most one 2-bit symbol per cycle. Each channel keeps its
//   own detector state, a match level and a saturating hit counter.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NCH]     channel i has a symbol pending
//   req_num    [2*NCH]   symbol of channel i on bits [2i+1:2i]
//   req_ready  [NCH]     one-hot grant, combinational; accepted when valid&ready
//   clr        clear request for channel clr_sel
//   clr_sel    [CH_W]    channel to clear (>= NCH ignored)
//   hit_valid  one-cycle pulse: a channel just reached S3 from S2
//   hit_ch     [CH_W]    channel index qualifying hit_valid
//   match      [NCH]     level: channel state == S3
//   rd_sel     [CH_W]    counter readback select
//   rd_cnt     [CNT_W]   hit counter of channel rd_sel (0 when rd_sel >= NCH)

module pattern_match_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_valid,
  input  logic [2*NCH-1:0] req_num,
  output logic [NCH-1:0]   req_ready,
  input  logic             clr,
  input  logic [CH_W-1:0]  clr_sel,
  output logic             hit_valid,
  output logic [CH_W-1:0]  hit_ch,
  output logic [NCH-1:0]   match,
  input  logic [CH_W-1:0]  rd_sel,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

  logic [1:0]       state [NCH];
  logic [CNT_W-1:0] cnt   [NCH];
  logic [CH_W-1:0]  ptr;

  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  logic [NCH-1:0]   gnt;
  logic [1:0]       gnt_sym;
  logic [1:0]       gnt_state;
  logic [1:0]       gnt_next;
  logic             gnt_clr;
  logic             gnt_hit;

  // Detector transition; symbol 00 and any unlisted symbol hold the state.
  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] sym);
    logic [1:0] n;
    n = s;
    case (s)
      S0: if (sym == SYM_01) n = S1;
      S1: begin
        if (sym == SYM_10)      n = S2;
        else if (sym == SYM_11) n = S0;
      end
      S2: begin
        if (sym == SYM_01)      n = S1;
        else if (sym == SYM_11) n = S3;
      end
      S3: begin
        if (sym == SYM_01)      n = S1;
        else if (sym == SYM_10) n = S0;
      end
      default: n = S0;
    endcase
    return n;
  endfunction

  // Round-robin search: first valid channel at or after ptr, wrapping.
  // The granted channel's symbol and current state are picked up here so the
  // single shared engine only ever looks at one channel.
  always_comb begin : arb
    int c;
    c         = 0;
    gnt       = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    gnt_sym   = 2'b00;
    gnt_state = S0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!gnt_any && req_valid[c]) begin
        gnt_any   = 1'b1;
        gnt[c]    = 1'b1;
        gnt_idx   = CH_W'(c);
        gnt_sym   = req_num[2*c +: 2];
        gnt_state = state[c];
      end
    end
  end

  assign req_ready = rst_n ? gnt : '0;

  // A symbol accepted in the same cycle its channel is cleared is consumed but
  // discarded: the clear wins and no hit is produced.
  assign gnt_clr  = clr && (clr_sel == gnt_idx);
  assign gnt_next = fsm_next(gnt_state, gnt_sym);
  assign gnt_hit  = gnt_any && !gnt_clr && (gnt_state == S2) && (gnt_next == S3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      hit_valid <= 1'b0;
      hit_ch    <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= S0;
        cnt[i]   <= '0;
      end
    end else begin
      hit_valid <= gnt_hit;
      if (gnt_hit) hit_ch <= gnt_idx;

      if (gnt_any) ptr <= (gnt_idx == CH_W'(NCH-1)) ? '0 : gnt_idx + 1'b1;

      for (int i = 0; i < NCH; i++) begin
        if (clr && (clr_sel == CH_W'(i))) begin
          state[i] <= S0;
          cnt[i]   <= '0;
        end else if (gnt_any && (gnt_idx == CH_W'(i))) begin
          state[i] <= gnt_next;
          if (gnt_hit && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++) match[i] = (state[i] == S3);
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == CH_W'(i)) rd_cnt = cnt[i];
    end
  end

endmodule

// File: tb/tb_pattern_match_sched.sv
// tb/tb_pattern_match_sched.sv - self-checking bench for pattern_match_sched
module tb_pattern_match_sched;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_num;
  logic       clr;
  logic [1:0] clr_sel;
  logic [1:0] rd_sel;

  logic [3:0] req_ready, req_ready_s;
  logic       hit_valid, hit_valid_s;
  logic [1:0] hit_ch, hit_ch_s;
  logic [3:0] match, match_s;
  logic [7:0] rd_cnt;
  logic [1:0] rd_cnt_s;

  int checks   = 0;
  int failures = 0;

  // Reference model: progress through the 1-2-3 sequence per channel, an
  // unbounded hit tally (capped only when compared), and the RR pointer.
  int nxt_tab [4][4] = '{'{0, 1, 0, 0},
                         '{1, 1, 2, 0},
                         '{2, 1, 2, 3},
                         '{3, 1, 0, 3}};
  int m_st   [4];
  int m_hits [4];
  int m_ptr;
  int m_hv;
  int m_hc;

  logic [1:0] seq [4][16];
  int len [4];
  int pos [4];

  always #10 clk = ~clk;

  pattern_match_sched #(.NCH(4), .CNT_W(8), .CH_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_num(req_num),
    .req_ready(req_ready), .clr(clr), .clr_sel(clr_sel), .hit_valid(hit_valid),
    .hit_ch(hit_ch), .match(match), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  pattern_match_sched #(.NCH(4), .CNT_W(2), .CH_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_num(req_num),
    .req_ready(req_ready_s), .clr(clr), .clr_sel(clr_sel), .hit_valid(hit_valid_s),
    .hit_ch(hit_ch_s), .match(match_s), .rd_sel(rd_sel), .rd_cnt(rd_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] put(input int ch, input logic [1:0] s);
    logic [7:0] r;
    r = 8'(s) << (2 * ch);
    return r;
  endfunction

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i]   = 0;
      m_hits[i] = 0;
    end
    m_ptr = 0;
    m_hv  = 0;
    m_hc  = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] em;
    em = '0;
    for (int i = 0; i < NCH; i++) em[i] = (m_st[i] == 3);
    chk("match", match, em);
    chk("match_s", match_s, em);
    chk("hit_valid", hit_valid, m_hv);
    chk("hit_valid_s", hit_valid_s, m_hv);
    if (m_hv != 0) begin
      chk("hit_ch", hit_ch, m_hc);
      chk("hit_ch_s", hit_ch_s, m_hc);
    end
    for (int r = 0; r < NCH; r++) begin
      rd_sel = 2'(r);
      #1;
      chk("rd_cnt", rd_cnt, cap(m_hits[r], 255));
      chk("rd_cnt_s", rd_cnt_s, cap(m_hits[r], 3));
    end
  endtask

  // One clock of stimulus; called during the low phase of clk.
  task automatic cycle(input logic [3:0] v, input logic [7:0] n, input logic c,
                       input logic [1:0] cs, output int g);
    logic [3:0] er;
    int ch, sym, nx;
    req_valid = v;
    req_num   = n;
    clr       = c;
    clr_sel   = cs;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      ch = (m_ptr + k) % NCH;
      if (g < 0 && v[ch]) g = ch;
    end
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", req_ready, er);
    chk("req_ready_s", req_ready_s, er);
    @(posedge clk);
    m_hv = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NCH;
      if (!(c && int'(cs) == g)) begin
        sym = int'((n >> (2 * g)) & 8'h3);
        nx  = nxt_tab[m_st[g]][sym];
        if (m_st[g] == 2 && nx == 3) begin
          m_hv = 1;
          m_hc = g;
          m_hits[g]++;
        end
        m_st[g] = nx;
      end
    end
    if (c) begin
      m_st[cs]   = 0;
      m_hits[cs] = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic feed(input int ch, input logic [1:0] s);
    seq[ch][len[ch]] = s;
    len[ch]++;
  endtask

  function automatic bit streams_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NCH; i++) if (pos[i] < len[i]) e = 1'b0;
    return e;
  endfunction

  task automatic run_streams(input string tag);
    int iter, g;
    logic [3:0] v;
    logic [7:0] n;
    iter = 0;
    while (!streams_empty() && iter < 60) begin
      v = '0;
      n = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (pos[ch] < len[ch]) begin
          v[ch] = 1'b1;
          n = n | put(ch, seq[ch][pos[ch]]);
        end
      end
      cycle(v, n, 1'b0, 2'd0, g);
      if (g >= 0) pos[g]++;
      iter++;
    end
    chk({tag, "_drained"}, streams_empty(), 1);
    for (int i = 0; i < NCH; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [3:0] v;
    logic [7:0] n;
    logic c;
    logic [1:0] cs;

    for (int i = 0; i < NCH; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    model_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_num   = 8'h55;
    clr       = 1'b0;
    clr_sel   = 2'd0;
    rd_sel    = 2'd0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_ch", hit_ch, 0);
    for (int r = 0; r < NCH; r++) begin
      rd_sel = 2'(r);
      #1;
      chk("rst_rd_cnt", rd_cnt, 0);
    end
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel 1-2-3 on ch1.
    feed(1, 2'b01); feed(1, 2'b10); feed(1, 2'b11);
    run_streams("t2");
    chk("t2_hit_valid", hit_valid, 1);
    chk("t2_hit_ch", hit_ch, 1);
    chk("t2_match1", match[1], 1);
    rd_sel = 2'd1;
    #1;
    chk("t2_rd_cnt1", rd_cnt, 1);

    // Round-robin order from pointer 0, then lone ch2 with pointer at 3.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(4'hF, 8'h00, 1'b0, 2'd0, g);
      chk("t3_grant", g, k % NCH);
    end
    cycle(4'b0100, 8'h00, 1'b0, 2'd0, g);
    chk("t3_lone_ch2", g, 2);

    // Interleaved streams on ch0 and ch3.
    feed(0, 2'b01); feed(0, 2'b10); feed(0, 2'b11);
    feed(3, 2'b01); feed(3, 2'b00); feed(3, 2'b10); feed(3, 2'b11);
    run_streams("t4");
    chk("t4_match", match & 4'b1001, 4'b1001);
    rd_sel = 2'd0;
    #1;
    chk("t4_cnt0", rd_cnt, 1);
    rd_sel = 2'd3;
    #1;
    chk("t4_cnt3", rd_cnt, 1);

    // FSM edges on ch1.
    feed(1, 2'b01); feed(1, 2'b11);
    feed(1, 2'b01); feed(1, 2'b10); feed(1, 2'b11);
    feed(1, 2'b10);
    feed(1, 2'b01); feed(1, 2'b10); feed(1, 2'b11);
    feed(1, 2'b01); feed(1, 2'b10); feed(1, 2'b11);
    feed(1, 2'b11);
    run_streams("t5");
    chk("t5_hold_no_hit", hit_valid, 0);
    chk("t5_match1", match[1], 1);

    // Clear colliding with a grant to the same channel.
    feed(2, 2'b01); feed(2, 2'b10);
    run_streams("t6a");
    cycle(4'b0100, put(2, 2'b11), 1'b1, 2'd2, g);
    chk("t6_clr_grant", g, 2);
    chk("t6_clr_no_hit", hit_valid, 0);
    chk("t6_clr_match", match[2], 0);
    // Clear of another channel does not disturb a grant.
    cycle(4'b0001, put(0, 2'b01), 1'b1, 2'd1, g);
    chk("t6_other_clr_grant", g, 0);
    // Saturation: five hits on a freshly cleared ch0.
    cycle(4'b0000, 8'h00, 1'b1, 2'd0, g);
    for (int h = 0; h < 5; h++) begin
      feed(0, 2'b01); feed(0, 2'b10); feed(0, 2'b11);
    end
    run_streams("t6b");
    rd_sel = 2'd0;
    #1;
    chk("t6_cnt8", rd_cnt, 5);
    chk("t6_cnt_sat", rd_cnt_s, 3);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      v  = 4'($urandom_range(0, 15));
      n  = 8'($urandom);
      c  = ($urandom_range(0, 15) == 0);
      cs = 2'($urandom_range(0, 3));
      cycle(v, n, c, cs, g);
    end
    cycle(4'b0000, 8'h00, 1'b0, 2'd0, g);

    // Asynchronous reset while a hit pulse is showing.
    feed(0, 2'b01); feed(0, 2'b10); feed(0, 2'b11);
    run_streams("t1");
    chk("t1_pre_hit", hit_valid, 1);
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("t1_match", match, 0);
    chk("t1_hit_valid", hit_valid, 0);
    chk("t1_ready", req_ready, 0);
    for (int r = 0; r < NCH; r++) begin
      rd_sel = 2'(r);
      #1;
      chk("t1_rd_cnt", rd_cnt, 0);
    end
    model_reset();
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1000, put(3, 2'b01), 1'b0, 2'd0, g);
    chk("t1_after_grant", g, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
